// File: rtl/pv_sequencer.sv
// Step sequencer for the PV cell model: latches operands, launches the PV model,
// waits for its results, then drives the external subtractor to form Ipv = Iph - Id.
module pv_sequencer #(
  parameter int AD_DIV  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [31:0] Vd_in,
  input  logic [31:0] S_in,
  input  logic [31:0] T_in,
  output logic        sta,
  output logic        sta_ad,
  output logic [31:0] S,
  output logic [31:0] T,
  output logic [31:0] Vd,
  input  logic [31:0] Iph,
  input  logic [31:0] Id,
  input  logic        done_sig,
  output logic        sub_sta,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  input  logic [31:0] sub_result,
  input  logic        sub_done,
  output logic [31:0] Ipv,
  output logic        Ipv_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int ADW = (AD_DIV > 1) ? $clog2(AD_DIV) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADW-1:0] AD_LAST = ADW'(AD_DIV - 1);
  // Abort fires on the edge where the post-increment count would reach TIMEOUT.
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_PV, SUB, WAIT_SUB} state_t;

  state_t         state;
  logic [ADW-1:0] ad_cnt;
  logic [TW-1:0]  timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ad_cnt      <= '0;
      timer       <= '0;
      sta         <= 1'b0;
      sta_ad      <= 1'b0;
      S           <= '0;
      T           <= '0;
      Vd          <= '0;
      sub_sta     <= 1'b0;
      sub_a       <= '0;
      sub_b       <= '0;
      Ipv         <= '0;
      Ipv_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sta       <= 1'b0;
      sta_ad    <= 1'b0;
      sub_sta   <= 1'b0;
      Ipv_valid <= 1'b0;

      if (step && (state != IDLE))
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (step) begin
            Vd <= Vd_in;
            if (ad_cnt == '0) begin
              S <= S_in;
              T <= T_in;
            end
            sta_ad <= (ad_cnt == '0);
            ad_cnt <= (ad_cnt == AD_LAST) ? '0 : ad_cnt + 1'b1;
            sta    <= 1'b1;
            busy   <= 1'b1;
            state  <= LAUNCH;
          end
        end

        LAUNCH: begin
          timer <= '0;
          state <= WAIT_PV;
        end

        WAIT_PV: begin
          if (done_sig) begin
            // sub_a/sub_b double as the latched Iph/Id and stay put until the next result.
            sub_a   <= Iph;
            sub_b   <= Id;
            sub_sta <= 1'b1;
            state   <= SUB;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SUB: begin
          timer <= '0;
          state <= WAIT_SUB;
        end

        WAIT_SUB: begin
          if (sub_done) begin
            Ipv       <= sub_result;
            Ipv_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pv_sequencer.sv
// Bench for pv_sequencer: vector table of full steps with a result scoreboard, plus
// hand-written timeout, stray-handshake and mid-operation reset sequences.
module tb_pv_sequencer;

  logic        clk;
  logic        rst;
  logic        step, to_step;
  logic [31:0] Vd_in, S_in, T_in;
  logic [31:0] Iph, Id, sub_result;
  logic        done_sig, sub_done, to_done, to_sub_done;

  logic        sta, sta_ad, sub_sta, Ipv_valid, busy, timeout_err, overrun;
  logic [31:0] S, T, Vd, sub_a, sub_b, Ipv;

  logic        to_sta, to_sta_ad, to_sub_sta, to_valid, to_busy, to_err, to_overrun;
  logic [31:0] to_S, to_T, to_Vd, to_sub_a, to_sub_b, to_Ipv;

  pv_sequencer #(.AD_DIV(3), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .step(step), .Vd_in(Vd_in), .S_in(S_in), .T_in(T_in),
    .sta(sta), .sta_ad(sta_ad), .S(S), .T(T), .Vd(Vd), .Iph(Iph), .Id(Id),
    .done_sig(done_sig), .sub_sta(sub_sta), .sub_a(sub_a), .sub_b(sub_b),
    .sub_result(sub_result), .sub_done(sub_done), .Ipv(Ipv), .Ipv_valid(Ipv_valid),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun)
  );

  pv_sequencer #(.AD_DIV(1), .TIMEOUT(15)) dut_to (
    .clk(clk), .rst(rst), .step(to_step), .Vd_in(Vd_in), .S_in(S_in), .T_in(T_in),
    .sta(to_sta), .sta_ad(to_sta_ad), .S(to_S), .T(to_T), .Vd(to_Vd), .Iph(Iph), .Id(Id),
    .done_sig(to_done), .sub_sta(to_sub_sta), .sub_a(to_sub_a), .sub_b(to_sub_b),
    .sub_result(sub_result), .sub_done(to_sub_done), .Ipv(to_Ipv), .Ipv_valid(to_valid),
    .busy(to_busy), .timeout_err(to_err), .overrun(to_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vd, s, t, iph, id, res;
    int          pv_lat, sub_lat, mode;  // mode: 0 plain, 1 overrun in WAIT_PV, 2 stray handshakes in SUB
    logic        exp_ad;
    logic [31:0] exp_s, exp_t;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          valid_cnt = 0;
  int          to_sub_sta_cnt = 0;

  always @(posedge clk) begin
    if (Ipv_valid) valid_cnt++;
    if (to_sub_sta) to_sub_sta_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int          vbefore;
    logic [31:0] e;
    vbefore = valid_cnt;
    Vd_in = v.vd; S_in = v.s; T_in = v.t; step = 1'b1;
    exp_q.push_back(v.res);
    tick();
    step = 1'b0;
    chk("sta", sta, 1);
    chk("sta_ad", sta_ad, v.exp_ad);
    chk("busy_launch", busy, 1);
    chk("Vd", Vd, v.vd);
    chk("S", S, v.exp_s);
    chk("T", T, v.exp_t);
    tick();
    chk("sta_single", sta, 0);
    chk("sta_ad_single", sta_ad, 0);
    if (v.mode == 1) begin
      Vd_in = 32'hDEADBEEF; S_in = 32'hBAADF00D; step = 1'b1;
      tick();
      step = 1'b0;
      chk("overrun_set", overrun, 1);
      chk("Vd_hold_overrun", Vd, v.vd);
      chk("S_hold_overrun", S, v.exp_s);
      chk("busy_overrun", busy, 1);
      repeat (v.pv_lat - 1) tick();
    end else begin
      repeat (v.pv_lat) tick();
    end
    Iph = v.iph; Id = v.id; done_sig = 1'b1;
    tick();
    done_sig = 1'b0; Iph = 32'h0; Id = 32'h0;
    chk("sub_sta", sub_sta, 1);
    chk("sub_a", sub_a, v.iph);
    chk("sub_b", sub_b, v.id);
    if (v.mode == 2) begin
      done_sig = 1'b1; sub_done = 1'b1; sub_result = 32'hFFFFFFFF;
      tick();
      done_sig = 1'b0; sub_done = 1'b0;
      chk("stray_sub_busy", busy, 1);
      chk("stray_sub_valid", Ipv_valid, 0);
      chk("stray_sub_sta", sub_sta, 0);
    end else begin
      tick();
      chk("sub_sta_single", sub_sta, 0);
    end
    repeat (v.sub_lat) tick();
    chk("sub_a_hold", sub_a, v.iph);
    chk("sub_b_hold", sub_b, v.id);
    sub_result = v.res; sub_done = 1'b1;
    tick();
    sub_done = 1'b0; sub_result = 32'h0;
    chk("busy_done", busy, 0);
    chk("Ipv_valid", Ipv_valid, 1);
    if (Ipv_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Ipv", Ipv, e);
    end
    tick();
    chk("Ipv_valid_single", Ipv_valid, 0);
    chk("valid_count", valid_cnt - vbefore, 1);
    $display("txn %0d: Vd=%h S=%h T=%h sta_ad=%b Ipv=%h", idx, Vd, S, T, v.exp_ad, Ipv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vb;
    vec_t hv;
    rst = 1'b1; step = 1'b0; to_step = 1'b0;
    Vd_in = '0; S_in = '0; T_in = '0; Iph = '0; Id = '0; sub_result = '0;
    done_sig = 1'b0; sub_done = 1'b0; to_done = 1'b0; to_sub_done = 1'b0;

    tbl[0] = '{32'h41A00000, 32'h447A0000, 32'h43950000, 32'h40A00000, 32'h3F800000, 32'h40800000, 20, 3, 0, 1'b1, 32'h447A0000, 32'h43950000};
    tbl[1] = '{32'h41A80000, 32'h44480000, 32'h43960000, 32'h40400000, 32'h3F000000, 32'h40200000,  5, 1, 1, 1'b0, 32'h447A0000, 32'h43950000};
    tbl[2] = '{32'h41B00000, 32'h44160000, 32'h43970000, 32'h40000000, 32'h3F800000, 32'h3F800000,  2, 0, 0, 1'b0, 32'h447A0000, 32'h43950000};
    tbl[3] = '{32'h41B80000, 32'h43C80000, 32'h43980000, 32'h40800000, 32'h40000000, 32'h40000000,  1, 2, 0, 1'b1, 32'h43C80000, 32'h43980000};
    tbl[4] = '{32'h41C00000, 32'h43960000, 32'h43990000, 32'h41200000, 32'h3F800000, 32'h41100000,  3, 2, 2, 1'b0, 32'h43C80000, 32'h43980000};
    tbl[5] = '{32'h41C80000, 32'h43480000, 32'h439A0000, 32'h40E00000, 32'h40400000, 32'h40800000,  0, 1, 0, 1'b0, 32'h43C80000, 32'h43980000};
    tbl[6] = '{32'h41D00000, 32'h42C80000, 32'h439B0000, 32'h41000000, 32'h40C00000, 32'h40000000,  4, 0, 0, 1'b1, 32'h42C80000, 32'h439B0000};

    repeat (3) tick();
    chk("rst_sta", sta, 0);
    chk("rst_sta_ad", sta_ad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_S", S, 0);
    chk("rst_Vd", Vd, 0);
    chk("rst_sub_a", sub_a, 0);
    chk("rst_Ipv", Ipv, 0);
    chk("rst_valid", Ipv_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick();

    // Stray handshakes while idle
    vb = valid_cnt;
    done_sig = 1'b1; sub_done = 1'b1; sub_result = 32'h12345678;
    tick();
    done_sig = 1'b0; sub_done = 1'b0; sub_result = '0;
    tick();
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_sub_sta", sub_sta, 0);
    chk("stray_idle_Ipv", Ipv, 0);
    chk("stray_idle_valid", valid_cnt - vb, 0);

    for (int i = 0; i < 7; i++) begin
      chk("overrun_before", overrun, (i >= 2) ? 1 : 0);
      do_txn(tbl[i], i);
    end
    chk("overrun_sticky", overrun, 1);
    chk("timeout_clear", timeout_err, 0);
    chk("queue_empty", exp_q.size(), 0);

    // Reset in WAIT_SUB; ad_cnt is 1 here, so this step does not refresh S/T
    Vd_in = 32'h42000000; S_in = 32'h44000000; T_in = 32'h43A00000; step = 1'b1;
    tick();
    step = 1'b0;
    chk("pre_rst_sta_ad", sta_ad, 0);
    repeat (3) tick();
    Iph = 32'h40400000; Id = 32'h3F800000; done_sig = 1'b1;
    tick();
    done_sig = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", busy, 1);
    vb = valid_cnt;
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_S", S, 0);
    chk("mid_rst_Vd", Vd, 0);
    chk("mid_rst_sub_a", sub_a, 0);
    chk("mid_rst_sub_b", sub_b, 0);
    chk("mid_rst_Ipv", Ipv, 0);
    chk("mid_rst_overrun", overrun, 0);
    tick();
    rst = 1'b0; sub_result = 32'h40000000; sub_done = 1'b1;
    tick();
    sub_done = 1'b0;
    tick();
    chk("post_rst_valid", valid_cnt - vb, 0);
    chk("post_rst_Ipv", Ipv, 0);
    chk("post_rst_busy", busy, 0);
    hv = '{32'h42100000, 32'h44200000, 32'h43A10000, 32'h40C00000, 32'h40000000, 32'h40800000, 6, 2, 0, 1'b1, 32'h44200000, 32'h43A10000};
    do_txn(hv, 7);

    // Timeout on the TIMEOUT=15 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vb = to_sub_sta_cnt;
    Vd_in = 32'h41F00000; to_step = 1'b1;
    tick();
    to_step = 1'b0;
    chk("to_sta", to_sta, 1);
    tick();
    repeat (14) tick();
    chk("to_busy_c15", to_busy, 1);
    chk("to_err_c15", to_err, 0);
    tick();
    chk("to_err_c16", to_err, 1);
    chk("to_busy_c16", to_busy, 0);
    chk("to_no_sub_sta", to_sub_sta_cnt - vb, 0);
    chk("to_no_valid", to_valid, 0);
    $display("timeout: err=%b busy=%b", to_err, to_busy);

    Vd_in = 32'h41F80000; to_step = 1'b1;
    tick();
    to_step = 1'b0;
    chk("to2_sta", to_sta, 1);
    chk("to2_sta_ad", to_sta_ad, 1);
    chk("to2_Vd", to_Vd, 32'h41F80000);
    repeat (4) tick();
    Iph = 32'h40A00000; Id = 32'h40000000; to_done = 1'b1;
    tick();
    to_done = 1'b0;
    chk("to2_sub_sta", to_sub_sta, 1);
    chk("to2_sub_a", to_sub_a, 32'h40A00000);
    chk("to2_sub_b", to_sub_b, 32'h40000000);
    repeat (2) tick();
    sub_result = 32'h40400000; to_sub_done = 1'b1;
    tick();
    to_sub_done = 1'b0;
    chk("to2_valid", to_valid, 1);
    chk("to2_Ipv", to_Ipv, 32'h40400000);
    chk("to2_err_sticky", to_err, 1);
    $display("timeout recovery: Ipv=%h", to_Ipv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
